// File: rtl/sprite_pkg.sv
// Shared sprite constants for the coin render path: geometry, colour format,
// reserved ids and the transparency key.
package sprite_pkg;

    localparam int          SPR_W      = 16;
    localparam int          COLOR_W    = 12;
    localparam int          COORD_W    = 10;
    localparam int          ID_W       = 6;
    localparam logic [5:0]  NULL_ID    = 6'd63;
    localparam logic [5:0]  COIN1      = 6'd4;
    localparam logic [5:0]  COIN2      = 6'd5;
    localparam logic [5:0]  COIN3      = 6'd6;
    localparam logic [5:0]  COIN4      = 6'd7;
    localparam logic [11:0] TRANSP_KEY = 12'hF0F;

endpackage

// File: rtl/sprite_rom.sv
// Sprite bitmap ROM, one registered read per clock, no reset on the data path.
// Contents are a built-in pattern computed from the address.
module sprite_rom #(
    parameter int                 NUM_SPRITES = 8,
    parameter int                 SPR_W       = 16,
    parameter int                 COLOR_W     = 12,
    parameter logic [COLOR_W-1:0] TRANSP_KEY  = 12'hF0F,
    parameter string              ROM_FILE    = "sprites.hex",
    parameter int                 AW          = 11
) (
    input  logic               clk,
    input  logic [AW-1:0]      addr,
    output logic [COLOR_W-1:0] data
);

    localparam int DEPTH = NUM_SPRITES * SPR_W * SPR_W;

    // Pattern: colour = {slot,row,col}; transparent where row and col agree mod 4.
    function automatic logic [COLOR_W-1:0] pattern(input logic [AW-1:0] a);
        logic [3:0] c, r, s;
        c = 4'(a % SPR_W);
        r = 4'((a / SPR_W) % SPR_W);
        s = 4'(a / (SPR_W * SPR_W));
        if (r[1:0] == c[1:0]) return TRANSP_KEY;
        return COLOR_W'({s, r, c});
    endfunction

    always_ff @(posedge clk) data <= pattern(addr);

endmodule

// File: rtl/coin_sprite_render.sv
// Per-pixel coin sprite lookup: frame-shadowed id/position, box test, ROM read,
// transparency keying. Three-stage pipe, one pixel per clock, no stalls.
module coin_sprite_render
    import sprite_pkg::COORD_W;
    import sprite_pkg::ID_W;
    import sprite_pkg::NULL_ID;
#(
    parameter int                 SPR_W       = sprite_pkg::SPR_W,
    parameter int                 NUM_SPRITES = 8,
    parameter int                 COLOR_W     = sprite_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0] TRANSP_KEY  = sprite_pkg::TRANSP_KEY,
    parameter string              ROM_FILE    = "sprites.hex"
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [ID_W-1:0]    id,
    input  logic [COORD_W-1:0] obj_x,
    input  logic [COORD_W-1:0] obj_y,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               out_valid,
    output logic               out_hit,
    output logic [COLOR_W-1:0] out_color
);

    localparam int STAGES = 2;
    localparam int LW     = $clog2(SPR_W);
    localparam int SW     = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int AW     = SW + 2 * LW;

    logic [ID_W-1:0]    sh_id;
    logic [COORD_W-1:0] sh_x, sh_y;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_id <= NULL_ID;
            sh_x  <= '0;
            sh_y  <= '0;
        end else if (frame_start) begin
            sh_id <= id;
            sh_x  <= obj_x;
            sh_y  <= obj_y;
        end
    end

    // S0: offsets are 11-bit so a pixel left of/above the sprite goes negative
    // instead of wrapping onto a valid column.
    logic             active, in_box;
    logic [COORD_W:0] dx, dy;

    assign active = (sh_id != NULL_ID) && (32'(sh_id) < NUM_SPRITES);
    assign dx     = {1'b0, pix_x} - {1'b0, sh_x};
    assign dy     = {1'b0, pix_y} - {1'b0, sh_y};
    assign in_box = active && !dx[COORD_W] && !dy[COORD_W]
                    && (dx[COORD_W-1:0] < COORD_W'(SPR_W))
                    && (dy[COORD_W-1:0] < COORD_W'(SPR_W));

    logic [STAGES:0]   vld_pipe;
    logic [STAGES-1:0] box_pipe;
    logic [LW-1:0]     s0_dx, s0_dy;
    logic [SW-1:0]     s0_slot;
    logic [COLOR_W-1:0] rom_data;
    logic               hit_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            box_pipe <= '0;
            s0_dx    <= '0;
            s0_dy    <= '0;
            s0_slot  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], pix_valid};
            box_pipe <= {box_pipe[0], in_box};
            s0_dx    <= dx[LW-1:0];
            s0_dy    <= dy[LW-1:0];
            s0_slot  <= sh_id[SW-1:0];
        end
    end

    // S1: ROM is read every cycle; invalid slots just carry don't-care pixels.
    sprite_rom #(
        .NUM_SPRITES(NUM_SPRITES),
        .SPR_W      (SPR_W),
        .COLOR_W    (COLOR_W),
        .TRANSP_KEY (TRANSP_KEY),
        .ROM_FILE   (ROM_FILE),
        .AW         (AW)
    ) u_rom (
        .clk (clk),
        .addr({s0_slot, s0_dy, s0_dx}),
        .data(rom_data)
    );

    // S2
    assign hit_c = box_pipe[1] && (rom_data != TRANSP_KEY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_hit   <= 1'b0;
            out_color <= '0;
        end else begin
            out_hit   <= hit_c;
            out_color <= hit_c ? rom_data : '0;
        end
    end

    assign out_valid = vld_pipe[STAGES];

endmodule
